dnn_mem_server_fix: RTL and testbench

- Memory responder on the far side of the inference engine's mem_addr/mem_data read port.
- Holds activations (image plus bias word) and layer weights as signed fixed-point words.
- Loaded from a streaming valid/ready write channel.
- Answers engine reads with one-cycle registered latency.
- Sits between the host/testbench loader and the fixed-point ReLU inference engine.

---
 rtl/dnn_mem_server_fix.sv | 133 +++++++++++++
 tb/tb_dnn_mem_server_fix.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_mem_server_fix.sv
// dnn_mem_server_fix: signed fixed-point word store with a streaming loader and a 1-cycle read port.
// Define DNN_MEM_CKSUM_EN to add the ld_cksum running sum of written words.
module dnn_mem_server_fix #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 16384
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_start,
    input  logic [ADDR_WIDTH-1:0]        ld_base,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic signed [DATA_WIDTH-1:0] ld_data,
    input  logic                         ld_last,
    output logic                         ld_done,
    output logic [ADDR_WIDTH-1:0]        ld_count,
    output logic                         ld_err,
`ifdef DNN_MEM_CKSUM_EN
    output logic [15:0]                  ld_cksum,
`endif
    input  logic                         lock,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic signed [DATA_WIDTH-1:0] mem_data,
    output logic [1:0]                   dbg_state
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = MEM_DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic                    hs;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // A word transfers on a rising edge where ld_valid && ld_ready; ld_ready is only
    // high in LOAD with lock low, and the loader holds ld_data/ld_last until it transfers.
    assign hs          = ld_valid && ld_ready;
    assign wr_in_range = ({1'b0, wptr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, mem_addr} < DEPTH_EXT);
    assign wr_en       = hs && wr_in_range;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ready = !lock;
                if (ld_valid && !lock && ld_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (state_q == IDLE && ld_start) begin
            wptr     <= ld_base;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (hs) begin
            wptr     <= wptr + ADDR_WIDTH'(1);
            ld_count <= ld_count + ADDR_WIDTH'(1);
            if (!wr_in_range) begin
                ld_err <= 1'b1;
            end
        end
    end

`ifdef DNN_MEM_CKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cksum <= '0;
        end else if (state_q == IDLE && ld_start) begin
            ld_cksum <= '0;
        end else if (wr_en) begin
            ld_cksum <= ld_cksum + {{(16-DATA_WIDTH){ld_data[DATA_WIDTH-1]}}, ld_data};
        end
    end
`endif

    // Storage has no reset so it maps onto block RAM; a burst interrupted by reset keeps its words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[IDX_W-1:0]] <= ld_data;
        end
    end

    // Read-before-write: a same-cycle write to mem_addr shows up on the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data <= '0;
        end else if (rd_in_range) begin
            mem_data <= mem[mem_addr[IDX_W-1:0]];
        end else begin
            mem_data <= '0;
        end
    end

endmodule

// File: tb/tb_dnn_mem_server_fix.sv
// Bench for dnn_mem_server_fix: directed bursts plus randomized bursts checked against an array model.
// Define DNN_MEM_CKSUM_EN to also check ld_cksum.
module tb_dnn_mem_server_fix;
    localparam int DW    = 6;
    localparam int AW    = 16;
    localparam int DEPTH = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_start = 1'b0;
    logic [AW-1:0] ld_base = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_done;
    logic [AW-1:0] ld_count;
    logic          ld_err;
    logic          lock = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data;
    logic [1:0]    dbg_state;
`ifdef DNN_MEM_CKSUM_EN
    logic [15:0]   ld_cksum;
`endif

    // Reference model: word array indexed by address, plus the current burst's expectations
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wq [$];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] cur_base;
    logic          exp_err;
    logic [15:0]   exp_ck;
    int            n_tests = 0;
    int            n_fail = 0;

    dnn_mem_server_fix #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .ld_err    (ld_err),
`ifdef DNN_MEM_CKSUM_EN
        .ld_cksum  (ld_cksum),
`endif
        .lock      (lock),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_accept(input int idx);
        logic [AW-1:0] a;
        int v;
        a = cur_base + AW'(idx);
        if (a < DEPTH) begin
            model_mem[a] = wq[idx];
            v = $signed(wq[idx]);
            exp_ck = exp_ck + v[15:0];
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    // Driver tasks: all called at a falling edge, return at a falling edge
    task automatic start_burst(input logic [AW-1:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        cur_base = base;
        exp_err  = 1'b0;
        exp_ck   = '0;
        @(negedge clk);
        ld_start = 1'b0;
        #1;
        chk("start_ready", ld_ready, 1);
        chk("start_count", ld_count, 0);
        chk("start_err", ld_err, 0);
    endtask

    // lock_mode: 0 none, 1 high for 5 cycles from lock_at, 2 random
    task automatic send_words(input int lock_mode, input int lock_at, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < wq.size() && cyc < 4000) begin
            case (lock_mode)
                0:       lock = 1'b0;
                1:       lock = (cyc >= lock_at && cyc < lock_at + 5);
                default: lock = ($urandom_range(0, 4) == 0);
            endcase
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_data  = wq[i];
            ld_last  = (i == wq.size() - 1);
            #1;
            chk("ld_ready", ld_ready, {31'd0, !lock});
            chk("ld_count_live", ld_count, i);
            if (ld_valid && !lock) begin
                model_accept(i);
                i++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("burst_progress", i, wq.size());
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        lock     = 1'b0;
    endtask

    task automatic end_burst(input int n);
        #1;
        chk("ld_done", ld_done, 1);
        chk("done_ready", ld_ready, 0);
        chk("ld_count_final", ld_count, n);
        chk("ld_err", ld_err, {31'd0, exp_err});
`ifdef DNN_MEM_CKSUM_EN
        chk("ld_cksum", ld_cksum, {16'd0, exp_ck});
`endif
        @(negedge clk);
        #1;
        chk("done_pulse", ld_done, 0);
        chk("idle_state", dbg_state, 0);
        chk("idle_ready", ld_ready, 0);
    endtask

    // Scoreboard: expectation queued when the address is presented, compared one cycle later
    task automatic read_chk(input logic [AW-1:0] a);
        mem_addr = a;
        exp_q.push_back((a < DEPTH) ? model_mem[a] : '0);
        @(negedge clk);
        chk($sformatf("read_%0h", a), mem_data, exp_q.pop_front());
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(DW'($urandom_range(0, 63)));
    endtask

    task automatic fill_const(input int n, input logic [DW-1:0] v);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(v);
    endtask

    initial begin
        logic [DW-1:0] old_val;
        logic [AW-1:0] base;
        int            n;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_count", ld_count, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a burst
        start_burst(16'h0010);
        wq.delete();
        wq.push_back(6'd7);
        wq.push_back(6'd9);
        ld_valid = 1'b1;
        ld_data  = wq[0];
        model_accept(0);
        @(negedge clk);
        ld_data = wq[1];
        model_accept(1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("mid_count", ld_count, 2);
        rst = 1'b0;
        #1;
        chk("midrst_ready", ld_ready, 0);
        chk("midrst_count", ld_count, 0);
        chk("midrst_err", ld_err, 0);
        chk("midrst_mem_data", mem_data, 0);
        chk("midrst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_burst(16'h0191);
        fill_const(1, 6'd21);
        send_words(0, 0, 1'b0);
        end_burst(1);
        read_chk(16'h0010);
        read_chk(16'h0011);
        read_chk(16'h0191);

        // 401 words of 6'b010000 from address 0, no stalls
        start_burst(16'h0000);
        fill_const(401, 6'b010000);
        send_words(0, 0, 1'b0);
        end_burst(401);
        read_chk(16'h0000);
        read_chk(16'h00C8);
        read_chk(16'h0190);

        // 401 random words with lock high for 5 cycles mid-stream
        start_burst(16'h0000);
        fill_random(401);
        send_words(1, 150, 1'b0);
        end_burst(401);
        for (int k = 147; k < 158; k++) read_chk(AW'(k));
        repeat (6) read_chk(AW'($urandom_range(0, 400)));

        // Burst crossing the top of memory
        start_burst(AW'(DEPTH - 2));
        fill_random(3);
        send_words(0, 0, 1'b0);
        end_burst(3);
        read_chk(AW'(DEPTH - 2));
        read_chk(AW'(DEPTH - 1));
        read_chk(AW'(DEPTH));
        read_chk(16'hFFFF);

        // Same-cycle read and write of 0x0200
        start_burst(16'h0200);
        fill_const(1, 6'd7);
        send_words(0, 0, 1'b0);
        end_burst(1);
        start_burst(16'h0200);
        fill_const(1, 6'b111101);
        old_val  = model_mem[16'h0200];
        mem_addr = 16'h0200;
        ld_valid = 1'b1;
        ld_data  = wq[0];
        ld_last  = 1'b1;
        model_accept(0);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("raw_old", mem_data, old_val);
        end_burst(1);
        chk("raw_new", mem_data, 6'b111101);

        // Randomized bursts with gaps and random lock, some running off the end of memory
        for (int r = 0; r < 8; r++) begin
            base = (r % 3 == 2) ? AW'($urandom_range(DEPTH - 30, DEPTH + 5))
                                : AW'($urandom_range(0, DEPTH - 50));
            n = $urandom_range(1, 40);
            start_burst(base);
            fill_random(n);
            send_words(2, 0, 1'b1);
            end_burst(n);
            repeat (4) read_chk(base + AW'($urandom_range(0, n - 1)));
        end

`ifdef DNN_MEM_CKSUM_EN
        start_burst(16'h0300);
        wq.delete();
        wq.push_back(6'd5);
        wq.push_back(6'b111101);
        wq.push_back(6'd31);
        wq.push_back(6'b100000);
        send_words(0, 0, 1'b0);
        end_burst(4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
